// File: rtl/stream_mux_if.sv
// Handshake bundle for the NCH:1 stream mux.
// master drives the producer/consumer side, slave is the mux itself.
interface stream_mux_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_chan;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/stream_mux_arbiter.sv
// NCH:1 stream mux with address or round-robin select.
// Output is a single register stage that sustains one word per cycle.
module stream_mux_arbiter #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input logic        clk,
  input logic        rst_n,
  stream_mux_if.slave bus
);
  localparam int SELW = $clog2(NCH);

  logic [SELW-1:0]    ptr;
  logic [SELW-1:0]    g;
  logic               gnt;
  logic               free;
  logic [2*NCH-1:0]   rot;
  logic [WIDTH-1:0]   din;
  logic [NCH-1:0]     rdy;
  logic [WIDTH-1:0]   dq;
  logic [SELW-1:0]    cq;
  logic               vq;
  int                 idx;

  assign free = !vq || bus.out_ready;

  // rot[k] is the valid of channel (ptr+k) mod NCH
  assign rot = {bus.in_valid, bus.in_valid} >> ptr;

  always_comb begin
    g   = '0;
    gnt = 1'b0;
    idx = 0;
    if (!bus.mode) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
          g   = SELW'(i);
          gnt = 1'b1;
        end
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (rot[k]) begin
          idx = int'(ptr) + k;
          if (idx >= NCH) idx = idx - NCH;
          g   = SELW'(idx);
          gnt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    din = '0;
    rdy = '0;
    for (int i = 0; i < NCH; i++) begin
      if (g == SELW'(i)) begin
        din = bus.in_data[i*WIDTH +: WIDTH];
        rdy[i] = rst_n && free && gnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vq  <= 1'b0;
      dq  <= '0;
      cq  <= '0;
      ptr <= '0;
    end else if (free) begin
      vq <= gnt;
      if (gnt) begin
        dq <= din;
        cq <= g;
        if (bus.mode)
          ptr <= (int'(g) == NCH - 1) ? '0 : g + 1'b1;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = dq;
  assign bus.out_chan  = cq;
  assign bus.out_valid = vq;
endmodule

// File: tb/tb_stream_mux_arbiter.sv
// Directed bench for stream_mux_arbiter.
// Runs an NCH=4 and an NCH=3 instance off one clock and reset.
module tb_stream_mux_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stream_mux_if #(.WIDTH(8), .NCH(4)) ifa ();
  stream_mux_if #(.WIDTH(8), .NCH(3)) ifb ();

  stream_mux_arbiter #(.WIDTH(8), .NCH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );
  stream_mux_arbiter #(.WIDTH(8), .NCH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic       mv;
  logic [7:0] md;
  logic [1:0] mc;
  logic       mfree;
  logic [3:0] mrdy;

  initial begin
    rst_n         = 1'b0;
    ifa.mode      = 1'b0;
    ifa.sel       = '0;
    ifa.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ifa.in_valid  = '0;
    ifa.out_ready = 1'b0;
    ifb.mode      = 1'b0;
    ifb.sel       = '0;
    ifb.in_data   = {8'hA2, 8'hA1, 8'hA0};
    ifb.in_valid  = '0;
    ifb.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(ifa.out_valid), 0);
    chk("rst_data", 32'(ifa.out_data), 0);
    chk("rst_chan", 32'(ifa.out_chan), 0);
    chk("rst_rdy", 32'(ifa.in_ready), 0);
    rst_n = 1'b1;

    // fixed address select
    @(negedge clk);
    ifa.sel       = 2'd2;
    ifa.in_valid  = 4'b1111;
    ifa.out_ready = 1'b1;
    #1 chk("m0_rdy", 32'(ifa.in_ready), 32'b0100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("m0_data", 32'(ifa.out_data), 32'hA2);
      chk("m0_chan", 32'(ifa.out_chan), 2);
      chk("m0_valid", 32'(ifa.out_valid), 1);
    end

    // round robin, all valid, no bubbles
    ifa.mode = 1'b1;
    #1 chk("rr_rdy0", 32'(ifa.in_ready), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_chan", 32'(ifa.out_chan), 32'(i % 4));
      chk("rr_data", 32'(ifa.out_data), 32'(8'hA0 + i % 4));
      chk("rr_valid", 32'(ifa.out_valid), 1);
    end

    // skip and wrap
    ifa.in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("skip_chan", 32'(ifa.out_chan), (i % 2 == 0) ? 0 : 3);
    end

    // backpressure
    ifa.out_ready = 1'b0;
    #1 chk("bp_rdy", 32'(ifa.in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_data", 32'(ifa.out_data), 32'hA3);
      chk("bp_chan", 32'(ifa.out_chan), 3);
      chk("bp_valid", 32'(ifa.out_valid), 1);
      chk("bp_rdy", 32'(ifa.in_ready), 0);
    end
    ifa.out_ready = 1'b1;
    #1 chk("rel_rdy", 32'(ifa.in_ready), 32'b0001);
    @(negedge clk);
    chk("rel_chan", 32'(ifa.out_chan), 0);
    chk("rel_data", 32'(ifa.out_data), 32'hA0);

    // async reset with a word held
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ifa.out_valid), 0);
    chk("arst_data", 32'(ifa.out_data), 0);
    chk("arst_chan", 32'(ifa.out_chan), 0);
    chk("arst_rdy", 32'(ifa.in_ready), 0);
    @(posedge clk);
    #1 chk("arst_edge", 32'(ifa.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_chan", 32'(ifa.out_chan), 0);
    chk("post_rst_valid", 32'(ifa.out_valid), 1);

    // known start state for the mode 0 sweep
    ifa.mode     = 1'b0;
    ifa.sel      = 2'd1;
    ifa.in_valid = 4'b0010;
    @(negedge clk);
    mv = 1'b1;
    md = 8'hA1;
    mc = 2'd1;
    chk("sweep_init", 32'(ifa.out_data), 32'(md));

    for (int s = 0; s < 4; s++) begin
      for (int v = 0; v < 16; v++) begin
        for (int r = 0; r < 2; r++) begin
          ifa.sel       = 2'(s);
          ifa.in_valid  = 4'(v);
          ifa.out_ready = r[0];
          mfree = !mv || r[0];
          mrdy  = (mfree && v[s]) ? 4'(1 << s) : 4'b0000;
          #1 chk("sw_rdy", 32'(ifa.in_ready), 32'(mrdy));
          if (mfree) begin
            mv = v[s];
            if (v[s]) begin
              md = 8'(8'hA0 + s);
              mc = 2'(s);
            end
          end
          @(negedge clk);
          chk("sw_valid", 32'(ifa.out_valid), 32'(mv));
          chk("sw_data", 32'(ifa.out_data), 32'(md));
          chk("sw_chan", 32'(ifa.out_chan), 32'(mc));
        end
      end
    end

    // NCH=3: out-of-range address, then rr wrap from ptr=2
    ifb.sel       = 2'd2;
    ifb.in_valid  = 3'b111;
    ifb.out_ready = 1'b1;
    @(negedge clk);
    chk("n3_chan", 32'(ifb.out_chan), 2);
    chk("n3_valid", 32'(ifb.out_valid), 1);
    ifb.sel = 2'd3;
    #1 chk("n3_oor_rdy", 32'(ifb.in_ready), 0);
    @(negedge clk);
    chk("n3_oor_valid", 32'(ifb.out_valid), 0);
    chk("n3_oor_data", 32'(ifb.out_data), 32'hA2);
    chk("n3_oor_chan", 32'(ifb.out_chan), 2);
    ifb.mode     = 1'b1;
    ifb.in_valid = 3'b010;
    @(negedge clk);
    chk("n3_rr1", 32'(ifb.out_chan), 1);
    ifb.in_valid = 3'b011;
    #1 chk("n3_wrap_rdy", 32'(ifb.in_ready), 32'b001);
    @(negedge clk);
    chk("n3_wrap_chan", 32'(ifb.out_chan), 0);
    ifb.in_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("n3_rr_seq", 32'(ifb.out_chan), 32'((i + 1) % 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
